// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: state encoding,
// ALU operation codes and the opcode/funct values the controller decodes.
// No ports; imported by multicycle_ctrl and multicycle_ctrl_funct_dec.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_WB_R     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_TRAP     = 4'd12
  } state_e;

  localparam logic [4:0] ALUOP_NOP = 5'd0;
  localparam logic [4:0] ALUOP_ADD = 5'd1;
  localparam logic [4:0] ALUOP_SUB = 5'd2;
  localparam logic [4:0] ALUOP_AND = 5'd3;
  localparam logic [4:0] ALUOP_OR  = 5'd4;
  localparam logic [4:0] ALUOP_XOR = 5'd5;
  localparam logic [4:0] ALUOP_NOR = 5'd6;
  localparam logic [4:0] ALUOP_SLT = 5'd7;
  localparam logic [4:0] ALUOP_SLL = 5'd8;
  localparam logic [4:0] ALUOP_SRL = 5'd9;
  localparam logic [4:0] ALUOP_SRA = 5'd10;
  localparam logic [4:0] ALUOP_MUL = 5'd11;
  localparam logic [4:0] ALUOP_DIV = 5'd12;
  localparam logic [4:0] ALUOP_LUI = 5'd13;
  localparam logic [4:0] ALUOP_BEQ = 5'd14;
  localparam logic [4:0] ALUOP_BNE = 5'd15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/multicycle_ctrl_funct_dec.sv
// Combinational ALU-operation decoder for the execute states.
// Ports:
//   opcode_i    instruction opcode field
//   funct_i     instruction funct field (used when opcode is R-type)
//   aluop_o     ALUOP_* code for the execute state
//   valid_o     1 when the opcode/funct pair is a supported ALU instruction
//   ovf_check_o 1 when ALU overflow must abort the instruction
module multicycle_ctrl_funct_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [4:0] aluop_o,
  output logic       valid_o,
  output logic       ovf_check_o
);

  always_comb begin
    aluop_o     = ALUOP_NOP;
    valid_o     = 1'b1;
    ovf_check_o = 1'b0;
    if (opcode_i == OP_RTYPE) begin
      case (funct_i)
        FN_SLL:          aluop_o = ALUOP_SLL;
        FN_SRL:          aluop_o = ALUOP_SRL;
        FN_SRA:          aluop_o = ALUOP_SRA;
        FN_ADD:          begin aluop_o = ALUOP_ADD; ovf_check_o = 1'b1; end
        FN_ADDU:         aluop_o = ALUOP_ADD;
        FN_SUB, FN_SUBU: aluop_o = ALUOP_SUB;
        FN_AND:          aluop_o = ALUOP_AND;
        FN_OR:           aluop_o = ALUOP_OR;
        FN_XOR:          aluop_o = ALUOP_XOR;
        FN_NOR:          aluop_o = ALUOP_NOR;
        FN_SLT:          aluop_o = ALUOP_SLT;
        FN_MUL:          begin aluop_o = ALUOP_MUL; ovf_check_o = 1'b1; end
        FN_DIV:          begin aluop_o = ALUOP_DIV; ovf_check_o = 1'b1; end
        default:         valid_o = 1'b0;
      endcase
    end else begin
      case (opcode_i)
        OP_ADDI: begin aluop_o = ALUOP_ADD; ovf_check_o = 1'b1; end
        OP_ANDI: aluop_o = ALUOP_AND;
        OP_ORI:  aluop_o = ALUOP_OR;
        OP_SLTI: aluop_o = ALUOP_SLT;
        OP_LUI:  aluop_o = ALUOP_LUI;
        default: valid_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback for one
// instruction at a time, driving datapath enables/selects and the ALU op.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr                     IR contents (valid from DECODE onward)
//   alu_zero, alu_overflow    ALU flags
//   mem_ready / mem_req, mem_we, iord   single memory port handshake
//   ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg,
//   alu_src_a, alu_src_b, aluop         datapath controls
//   trap                      fault flag (held until reset)
//   state                     current state for debug
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC on mem_ready
// DECODE   | branch target into ALUOut, dispatch on opcode
// EXEC_R   | R-type ALU op
// WB_R     | write rd
// EXEC_I   | immediate ALU op
// WB_I     | write rt
// MEM_ADDR | load/store address into ALUOut
// MEM_RD   | data read, wait for mem_ready
// MEM_WR   | data write, wait for mem_ready
// WB_MEM   | write MDR to rt
// BRANCH   | compare, take branch on alu_zero
// JUMP     | load jump target
// TRAP     | fault, absorbing until reset
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 255
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [4:0]  aluop,
  output logic        trap,
  output logic [3:0]  state
);

  localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [5:0] opcode, funct;
  logic [4:0] dec_aluop;
  logic       dec_valid, dec_ovf_check;
  logic       unused_instr;

  logic       mem_req_c, mem_we_c, iord_c, ir_we_c, pc_we_c, reg_we_c;
  logic       reg_dst_c, mem_to_reg_c, alu_src_a_c;
  logic [1:0] pc_src_c, alu_src_b_c;
  logic [4:0] aluop_c;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];

  multicycle_ctrl_funct_dec u_funct_dec (
    .opcode_i    (opcode),
    .funct_i     (funct),
    .aluop_o     (dec_aluop),
    .valid_o     (dec_valid),
    .ovf_check_o (dec_ovf_check)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    iord_c       = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    pc_src_c     = 2'd0;
    reg_we_c     = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'd0;
    aluop_c      = ALUOP_NOP;
    case (state_q)
      ST_FETCH: begin
        mem_req_c   = 1'b1;
        alu_src_b_c = 2'd1;
        aluop_c     = ALUOP_ADD;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = ST_DECODE;
        end else if (FETCH_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        alu_src_b_c = 2'd3;
        aluop_c     = ALUOP_ADD;
        case (opcode)
          OP_RTYPE:                                   state_d = ST_EXEC_R;
          OP_LW, OP_SW:                               state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:                             state_d = ST_BRANCH;
          OP_J:                                       state_d = ST_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI:  state_d = ST_EXEC_I;
          default:                                    state_d = ST_TRAP;
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = (state_q == ST_EXEC_I) ? 2'd2 : 2'd0;
        aluop_c     = dec_aluop;
        // Overflow on a checked op aborts before writeback.
        if (!dec_valid || (dec_ovf_check && alu_overflow))
          state_d = ST_TRAP;
        else
          state_d = (state_q == ST_EXEC_I) ? ST_WB_I : ST_WB_R;
      end
      ST_WB_R: begin
        reg_we_c  = 1'b1;
        reg_dst_c = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_WB_I: begin
        reg_we_c = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        aluop_c     = ALUOP_ADD;
        state_d     = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) state_d = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_WB_MEM: begin
        reg_we_c     = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a_c = 1'b1;
        aluop_c     = (opcode == OP_BEQ) ? ALUOP_BEQ : ALUOP_BNE;
        if (alu_zero) begin
          pc_we_c  = 1'b1;
          pc_src_c = 2'd1;
        end
        state_d = ST_FETCH;
      end
      ST_JUMP: begin
        pc_we_c  = 1'b1;
        pc_src_c = 2'd2;
        state_d  = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  // Reset overrides every output so nothing reaches the datapath mid-abort.
  always_comb begin
    mem_req    = ~rst & mem_req_c;
    mem_we     = ~rst & mem_we_c;
    iord       = ~rst & iord_c;
    ir_we      = ~rst & ir_we_c;
    pc_we      = ~rst & pc_we_c;
    pc_src     = rst ? 2'd0 : pc_src_c;
    reg_we     = ~rst & reg_we_c;
    reg_dst    = ~rst & reg_dst_c;
    mem_to_reg = ~rst & mem_to_reg_c;
    alu_src_a  = ~rst & alu_src_a_c;
    alu_src_b  = rst ? 2'd0 : alu_src_b_c;
    aluop      = rst ? ALUOP_NOP : aluop_c;
    trap       = ~rst & (state_q == ST_TRAP);
    state      = rst ? ST_FETCH : state_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        alu_zero, alu_overflow, mem_ready;
  logic        mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a, trap;
  logic [1:0]  pc_src, alu_src_b;
  logic [4:0]  aluop;
  logic [3:0]  state;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.FETCH_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluop(aluop), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  // Observed control word, field order matches mk() below.
  logic [22:0] ctl;
  assign ctl = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, aluop, trap, state};

  function automatic logic [22:0] mk(input logic req, input logic we, input logic io,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic sa, input logic [1:0] sb, input logic [4:0] op,
                                     input logic tr, input logic [3:0] st);
    return {req, we, io, irw, pcw, pcs, rw, rd, m2r, sa, sb, op, tr, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    logic [22:0] e;
    rst = 1'b1; mem_ready = 1'b1; alu_zero = 1'b0; alu_overflow = 1'b0;
    tick();
    #1;
    e = 23'd0;
    checks++; if (ctl !== e) begin errors++; $display("FAIL reset_hold got %06h exp %06h", ctl, e); end
    tick();
    rst = 1'b0; mem_ready = 1'b0;
    #1;
  endtask

  // FETCH with mem_ready in its first cycle, then DECODE; leaves DUT in the
  // first post-decode state.
  task automatic fetch_decode(input logic [31:0] ins, input string tag);
    logic [22:0] e;
    instr = ins; mem_ready = 1'b1;
    #1;
    e = mk(1,0,0,1,1,2'd0,0,0,0,0,2'd1,ALUOP_ADD,0,ST_FETCH);
    checks++; if (ctl !== e) begin errors++; $display("FAIL %s_fetch got %06h exp %06h", tag, ctl, e); end
    tick();
    mem_ready = 1'b0;
    #1;
    e = mk(0,0,0,0,0,2'd0,0,0,0,0,2'd3,ALUOP_ADD,0,ST_DECODE);
    checks++; if (ctl !== e) begin errors++; $display("FAIL %s_decode got %06h exp %06h", tag, ctl, e); end
    tick();
  endtask

  task automatic test_reset();
    logic [22:0] e;
    do_reset();
    e = mk(1,0,0,0,0,2'd0,0,0,0,0,2'd1,ALUOP_ADD,0,ST_FETCH);
    checks++; if (ctl !== e) begin errors++; $display("FAIL reset_fetch got %06h exp %06h", ctl, e); end
  endtask

  task automatic test_rtype();
    logic [22:0] e;
    int we_cnt = 0;
    fetch_decode(32'h00221820, "add");
    e = mk(0,0,0,0,0,2'd0,0,0,0,1,2'd0,ALUOP_ADD,0,ST_EXEC_R);
    checks++; if (ctl !== e) begin errors++; $display("FAIL add_exec got %06h exp %06h", ctl, e); end
    tick();
    e = mk(0,0,0,0,0,2'd0,1,1,0,0,2'd0,ALUOP_NOP,0,ST_WB_R);
    checks++; if (ctl !== e) begin errors++; $display("FAIL add_wb got %06h exp %06h", ctl, e); end
    for (int i = 0; i < 4; i++) begin
      if (reg_we) we_cnt++;
      tick();
    end
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL add_reg_we_count got %0d exp %0d", we_cnt, 1); end
    // SUB ignores overflow; state is back in FETCH after the loop above
    // because mem_ready stayed low only 3 cycles (below the timeout of 4).
    do_reset();
    fetch_decode(32'h00221822, "sub");
    alu_overflow = 1'b1;
    #1;
    e = mk(0,0,0,0,0,2'd0,0,0,0,1,2'd0,ALUOP_SUB,0,ST_EXEC_R);
    checks++; if (ctl !== e) begin errors++; $display("FAIL sub_exec got %06h exp %06h", ctl, e); end
    tick();
    alu_overflow = 1'b0;
    checks++; if (state !== ST_WB_R) begin errors++; $display("FAIL sub_ovf_no_trap got %0d exp %0d", state, ST_WB_R); end
    tick();
  endtask

  task automatic test_itype();
    logic [22:0] e;
    fetch_decode(32'h34220005, "ori");
    e = mk(0,0,0,0,0,2'd0,0,0,0,1,2'd2,ALUOP_OR,0,ST_EXEC_I);
    checks++; if (ctl !== e) begin errors++; $display("FAIL ori_exec got %06h exp %06h", ctl, e); end
    tick();
    e = mk(0,0,0,0,0,2'd0,1,0,0,0,2'd0,ALUOP_NOP,0,ST_WB_I);
    checks++; if (ctl !== e) begin errors++; $display("FAIL ori_wb got %06h exp %06h", ctl, e); end
    tick();
    checks++; if (state !== ST_FETCH) begin errors++; $display("FAIL ori_done got %0d exp %0d", state, ST_FETCH); end
  endtask

  task automatic test_lw();
    logic [22:0] e;
    fetch_decode(32'h8C220004, "lw");
    e = mk(0,0,0,0,0,2'd0,0,0,0,1,2'd2,ALUOP_ADD,0,ST_MEM_ADDR);
    checks++; if (ctl !== e) begin errors++; $display("FAIL lw_addr got %06h exp %06h", ctl, e); end
    tick();
    e = mk(1,0,1,0,0,2'd0,0,0,0,0,2'd0,ALUOP_NOP,0,ST_MEM_RD);
    for (int i = 0; i < 3; i++) begin
      checks++; if (ctl !== e) begin errors++; $display("FAIL lw_rd_wait%0d got %06h exp %06h", i, ctl, e); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== e) begin errors++; $display("FAIL lw_rd_ready got %06h exp %06h", ctl, e); end
    tick();
    mem_ready = 1'b0;
    #1;
    e = mk(0,0,0,0,0,2'd0,1,0,1,0,2'd0,ALUOP_NOP,0,ST_WB_MEM);
    checks++; if (ctl !== e) begin errors++; $display("FAIL lw_wb got %06h exp %06h", ctl, e); end
    tick();
    checks++; if (state !== ST_FETCH) begin errors++; $display("FAIL lw_done got %0d exp %0d", state, ST_FETCH); end
  endtask

  task automatic test_branch(input logic z);
    logic [22:0] e;
    fetch_decode(32'h14220003, "bne");
    alu_zero = z;
    #1;
    e = mk(0,0,0,0,z,z ? 2'd1 : 2'd0,0,0,0,1,2'd0,ALUOP_BNE,0,ST_BRANCH);
    checks++; if (ctl !== e) begin errors++; $display("FAIL bne_z%0d got %06h exp %06h", z, ctl, e); end
    tick();
    alu_zero = 1'b0;
    checks++; if (state !== ST_FETCH) begin errors++; $display("FAIL bne_done got %0d exp %0d", state, ST_FETCH); end
  endtask

  task automatic test_jump();
    logic [22:0] e;
    fetch_decode(32'h08000010, "j");
    e = mk(0,0,0,0,1,2'd2,0,0,0,0,2'd0,ALUOP_NOP,0,ST_JUMP);
    checks++; if (ctl !== e) begin errors++; $display("FAIL j_jump got %06h exp %06h", ctl, e); end
    tick();
    checks++; if (state !== ST_FETCH) begin errors++; $display("FAIL j_done got %0d exp %0d", state, ST_FETCH); end
  endtask

  task automatic test_overflow_trap();
    logic [22:0] e;
    int bad = 0;
    fetch_decode(32'h00221820, "ovf");
    alu_overflow = 1'b1;
    #1;
    checks++; if (state !== ST_EXEC_R) begin errors++; $display("FAIL ovf_exec got %0d exp %0d", state, ST_EXEC_R); end
    tick();
    alu_overflow = 1'b0; mem_ready = 1'b1;
    e = mk(0,0,0,0,0,2'd0,0,0,0,0,2'd0,ALUOP_NOP,1,ST_TRAP);
    for (int i = 0; i < 20; i++) begin
      if (ctl !== e) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_trap_sticky got %0d bad cycles exp 0", bad); end
    do_reset();
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL ovf_trap_clear got %0b exp 0", trap); end
  endtask

  task automatic test_bad_opcode();
    fetch_decode(32'hFC000000, "badop");
    checks++; if (state !== ST_TRAP || trap !== 1'b1) begin
      errors++; $display("FAIL badop_trap got state %0d trap %0b exp %0d 1", state, trap, ST_TRAP); end
    do_reset();
  endtask

  task automatic test_timeout();
    logic [22:0] e;
    mem_ready = 1'b0;
    e = mk(1,0,0,0,0,2'd0,0,0,0,0,2'd1,ALUOP_ADD,0,ST_FETCH);
    for (int i = 0; i < 4; i++) begin
      checks++; if (ctl !== e) begin errors++; $display("FAIL timeout_fetch%0d got %06h exp %06h", i, ctl, e); end
      tick();
    end
    checks++; if (state !== ST_TRAP || trap !== 1'b1) begin
      errors++; $display("FAIL timeout_trap got state %0d trap %0b exp %0d 1", state, trap, ST_TRAP); end
    do_reset();
  endtask

  task automatic test_reset_mid_write();
    logic [22:0] e;
    fetch_decode(32'hAC220004, "sw");
    tick();
    e = mk(1,1,1,0,0,2'd0,0,0,0,0,2'd0,ALUOP_NOP,0,ST_MEM_WR);
    checks++; if (ctl !== e) begin errors++; $display("FAIL sw_wr got %06h exp %06h", ctl, e); end
    rst = 1'b1;
    #1;
    checks++; if (ctl !== 23'd0) begin errors++; $display("FAIL sw_rst_outputs got %06h exp %06h", ctl, 23'd0); end
    tick();
    rst = 1'b0;
    #1;
    e = mk(1,0,0,0,0,2'd0,0,0,0,0,2'd1,ALUOP_ADD,0,ST_FETCH);
    checks++; if (ctl !== e) begin errors++; $display("FAIL sw_rst_fetch got %06h exp %06h", ctl, e); end
  endtask

  initial begin
    rst = 1'b1; instr = 32'd0; alu_zero = 1'b0; alu_overflow = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_itype();
    test_lw();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jump();
    test_overflow_trap();
    test_bad_opcode();
    test_timeout();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
